// File: rtl/shifter32seq_pkg.sv
// Shared ALU shift-path definitions: widths, FSM state encoding, direction codes.
package shifter32seq_pkg;

  localparam int DATA_W  = 32;
  localparam int SHAMT_W = 5;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage : shifter32seq_pkg

// File: rtl/shifter32seq_if.sv
// Request/response bundle between ALU operand select and the sequential shifter.
interface shifter32seq_if;
  import shifter32seq_pkg::*;

  logic               start;
  logic [DATA_W-1:0]  in;
  logic [SHAMT_W-1:0] shamt;
  logic               shiftdir;
  logic               shifta;
  logic [DATA_W-1:0]  out;
  logic               busy;
  logic               done;

  // Requester side: issues operations, observes the result.
  modport master (
    output start, in, shamt, shiftdir, shifta,
    input  out, busy, done
  );

  // Shifter side: accepts operations, returns the result.
  modport slave (
    input  start, in, shamt, shiftdir, shifta,
    output out, busy, done
  );

endinterface : shifter32seq_if

// File: rtl/shifter32b1.sv
// Single-position shift stage: shifts by one bit (or passes through) with
// zero fill on the left, and zero or sign fill on the right.
module shifter32b1
  import shifter32seq_pkg::*;
(
  input  logic [DATA_W-1:0] in_i,
  input  logic              shift_i,
  input  logic              shiftdir_i,
  input  logic              shifta_i,
  output logic [DATA_W-1:0] out_o
);

  // Select pass-through, left-by-one or right-by-one with the proper fill bit.
  always_comb begin
    out_o = in_i;
    if (!shift_i) begin
      out_o = in_i;
    end else if (shiftdir_i == DIR_LEFT) begin
      out_o = {in_i[DATA_W-2:0], 1'b0};
    end else begin
      out_o = {(shifta_i & in_i[DATA_W-1]), in_i[DATA_W-1:1]};
    end
  end

endmodule : shifter32b1

// File: rtl/shifter32seq.sv
// Multi-cycle 32-bit shift controller: applies one single-bit shift per clock
// until the requested amount is consumed, then pulses done for one cycle.
module shifter32seq
  import shifter32seq_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  shifter32seq_if.slave bus
);

  state_e             state_q;
  logic [DATA_W-1:0]  acc_q;
  logic [SHAMT_W-1:0] cnt_q;
  logic               dir_q;
  logic               arith_q;
  logic               busy_q;
  logic               done_q;
  logic [DATA_W-1:0]  shift_s;

  // The working register always passes through the one-bit stage; the FSM
  // decides whether the shifted value is taken.
  shifter32b1 u_stage (
    .in_i       (acc_q),
    .shift_i    (1'b1),
    .shiftdir_i (dir_q),
    .shifta_i   (arith_q),
    .out_o      (shift_s)
  );

  // Controller FSM with registered busy/done; reset aborts any operation silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= {DATA_W{1'b0}};
      cnt_q   <= {SHAMT_W{1'b0}};
      dir_q   <= DIR_RIGHT;
      arith_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            acc_q   <= bus.in;
            cnt_q   <= bus.shamt;
            dir_q   <= bus.shiftdir;
            arith_q <= bus.shifta;
            busy_q  <= 1'b1;
            if (bus.shamt != {SHAMT_W{1'b0}}) begin
              state_q <= SHIFT;
              done_q  <= 1'b0;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end else begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
          end
        end
        SHIFT: begin
          acc_q <= shift_s;
          cnt_q <= cnt_q - 5'd1;
          if (cnt_q == 5'd1) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            done_q  <= 1'b0;
          end
        end
        DONE: begin
          // Result holds in acc_q; a start seen here is dropped, not queued.
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out  = acc_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule : shifter32seq

// File: tb/tb_shifter32seq.sv
// Scoreboard bench for shifter32seq: expected results are queued when a
// request is issued and compared when done pulses.
module tb_shifter32seq;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  logic [31:0] sb_q[$];

  shifter32seq_if bus ();

  shifter32seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_shift(input logic [31:0] a, input logic [4:0] sh,
                                            input logic dir, input logic ar);
    logic signed [31:0] sa;
    sa = a;
    if (dir) return a << sh;
    else if (ar) return sa >>> sh;
    else return a >> sh;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Issue one request in the current (idle) cycle and follow it to done.
  // junk_mask[c] pulses start with random operands in cycle c.
  task automatic run_op(input string name, input logic [31:0] a, input logic [4:0] sh,
                        input logic dir, input logic ar, input logic [63:0] junk_mask);
    logic [31:0] exp_out;
    logic        done_seen;
    logic        exp_busy;
    exp_out = ref_shift(a, sh, dir, ar);
    sb_q.push_back(exp_out);
    bus.start = 1'b1; bus.in = a; bus.shamt = sh; bus.shiftdir = dir; bus.shifta = ar;
    vectors++;
    if (bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s idle_busy: got %b expected 0", name, bus.busy);
    end
    done_seen = 1'b0;
    for (int c = 1; c <= 40 && !done_seen; c++) begin
      next_cycle();
      bus.start    = junk_mask[c];
      bus.in       = $urandom;
      bus.shamt    = 5'($urandom_range(0, 31));
      bus.shiftdir = 1'($urandom_range(0, 1));
      bus.shifta   = 1'($urandom_range(0, 1));
      exp_busy = (c <= int'(sh) + 1);
      vectors++;
      if (bus.busy !== exp_busy) begin
        miscompares++;
        $display("FAIL %s busy@%0d: got %b expected %b", name, c, bus.busy, exp_busy);
      end
      if (bus.done === 1'b1) begin
        done_seen = 1'b1;
        exp_out = sb_q.pop_front();
        vectors++;
        if (c != int'(sh) + 1) begin
          miscompares++;
          $display("FAIL %s done_cycle: got %0d expected %0d", name, c, int'(sh) + 1);
        end
        vectors++;
        if (bus.out !== exp_out) begin
          miscompares++;
          $display("FAIL %s out: got %h expected %h", name, bus.out, exp_out);
        end
      end
    end
    if (!done_seen) begin
      vectors++;
      miscompares++;
      void'(sb_q.pop_front());
      $display("FAIL %s timeout: got no done expected done in cycle %0d", name, int'(sh) + 1);
    end
    next_cycle();
    bus.start = 1'b0;
    vectors++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.out !== exp_out) begin
      miscompares++;
      $display("FAIL %s after_done: got busy=%b done=%b out=%h expected 0 0 %h",
               name, bus.busy, bus.done, bus.out, exp_out);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.start = 1'b1; bus.in = $urandom; bus.shamt = 5'($urandom_range(1, 31));
      bus.shiftdir = 1'($urandom_range(0, 1)); bus.shifta = 1'($urandom_range(0, 1));
      next_cycle();
      vectors++;
      if (bus.out !== 32'h0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
        miscompares++;
        $display("FAIL reset: got out=%h busy=%b done=%b expected 0 0 0", bus.out, bus.busy, bus.done);
      end
    end
    rst = 1'b0;
    bus.start = 1'b0;
    next_cycle();
    vectors++;
    if (bus.out !== 32'h0 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_start_ignored: got out=%h busy=%b expected 0 0", bus.out, bus.busy);
    end
  endtask

  task automatic test_left();
    run_op("left4", 32'h0000_0001, 5'd4, 1'b1, 1'b0, 64'h0);
  endtask

  task automatic test_right_arith_logical();
    run_op("sra3", 32'h8000_0000, 5'd3, 1'b0, 1'b1, 64'h0);
    run_op("srl3", 32'h8000_0000, 5'd3, 1'b0, 1'b0, 64'h0);
    run_op("sra_pos", 32'h4000_00F0, 5'd7, 1'b0, 1'b1, 64'h0);
    run_op("sll_arith_ignored", 32'h8000_0001, 5'd2, 1'b1, 1'b1, 64'h0);
  endtask

  task automatic test_zero_max();
    run_op("zero", 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b1, 64'h0);
    run_op("max_left", 32'hFFFF_FFFF, 5'd31, 1'b1, 1'b0, 64'h0);
    run_op("max_sra", 32'h8000_0000, 5'd31, 1'b0, 1'b1, 64'h0);
  endtask

  task automatic test_start_while_busy();
    logic [63:0] mask;
    mask = 64'h0;
    mask[2] = 1'b1;
    mask[6] = 1'b1;
    run_op("busy_start", 32'h1234_5678, 5'd5, 1'b1, 1'b0, mask);
    run_op("accept_c7", 32'hCAFE_F00D, 5'd1, 1'b0, 1'b0, 64'h0);
  endtask

  task automatic test_reset_mid();
    bus.start = 1'b1; bus.in = 32'hA5A5_A5A5; bus.shamt = 5'd10;
    bus.shiftdir = 1'b1; bus.shifta = 1'b0;
    next_cycle();
    bus.start = 1'b0;
    next_cycle();
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    vectors++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.out !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_mid: got busy=%b done=%b out=%h expected 0 0 0", bus.busy, bus.done, bus.out);
    end
    for (int i = 0; i < 12; i++) begin
      next_cycle();
      vectors++;
      if (bus.done !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_mid_no_done: got done=%b expected 0", bus.done);
      end
    end
    run_op("after_abort", 32'h0F0F_0000, 5'd6, 1'b0, 1'b1, 64'h0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      run_op("random", $urandom, 5'($urandom_range(0, 31)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 64'h0);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.in = 32'h0; bus.shamt = 5'd0; bus.shiftdir = 1'b0; bus.shifta = 1'b0;
    #1;
    test_reset();
    test_left();
    test_right_arith_logical();
    test_zero_max();
    test_start_while_busy();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_shifter32seq
